seq_divider_su: RTL and testbench
=================================

Name: seq_divider_su

Overview:
Iterative radix-2 non-restoring integer divider. It is the inverse-operation companion to the Booth radix-8 multiplier. It uses the same start/busy/done handshake and the same per-operand sign_mode convention, so the two blocks are interchangeable behind one arithmetic-unit sequencer. It computes quotient and remainder with C-style truncation toward zero.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits (>= 4)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only when busy=0
dividend  in  WIDTH  dividend, captured on the accepted start edge
divisor  in  WIDTH  divisor, captured on the accepted start edge
sign_mode  in  2  [1]: dividend signed, [0]: divisor signed
quotient  out  WIDTH  result quotient, held until next accepted start
remainder  out  WIDTH  result remainder, held until next accepted start
done  out  1  single-cycle completion pulse
busy  out  1  operation in progress
div_by_zero  out  1  set with results when divisor==0; held with results

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, state=IDLE.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On start=1, capture the operands and sign_mode.
  - Form magnitudes: an operand is negated only if its mode bit=1 and its MSB=1. Use WIDTH+1-bit internal magnitude so 0x8000 is handled.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - If divisor==0, go to DONE directly. Otherwise load the counter with WIDTH-1 and go to CALC.
- CALC:
  - One quotient bit per cycle, non-restoring shift/add-or-subtract on a WIDTH+2-bit partial remainder.
  - Counter decrements each cycle; at 0 go to FIXUP. CALC lasts exactly WIDTH cycles.
- FIXUP:
  - If the partial remainder is negative, add the divisor magnitude back.
  - Apply negation: quotient if neg_q, remainder if neg_r.
  - Register the results. Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy:
  - Goes 1 on the edge that accepts start.
  - Stays 1 through CALC and FIXUP.
  - Is 0 in DONE, so a new start may be presented in the done cycle and is accepted on the next edge.
- Latency, normal path: done high in cycle WIDTH+2 after the accepting edge (18 cycles at WIDTH=16).
- Latency, divisor==0 path: done high in cycle 1 after the accepting edge.
- Divide-by-zero results: quotient = all ones, remainder = dividend (raw), div_by_zero=1.
- Overflow: the quotient is the low WIDTH bits of the exact result, two's-complement wrap, with no flag. This covers 0x8000/0xFFFF in mode 11 → 0x8000, and unsigned-dividend/negative-divisor cases such as 0xFFFF/0xFFFF in mode 01 → 0x0001.
- Remainder: |r| < |divisor|, and r has the sign of the dividend (0 if exact).
- start while busy=1: ignored, with no effect on the in-flight operation or on the outputs.
- Input changes after the accepting edge have no effect.
- Reset mid-operation: immediate return to the reset values; no done pulse is produced.
- quotient/remainder/div_by_zero update only in FIXUP (normal path) or on the IDLE→DONE transition (divide-by-zero path), never mid-CALC.

Decomposition:
- Shared package arith_pkg:
  - FSM state encoding (IDLE/CALC/FIXUP/DONE).
  - SIGN_A_BIT=1 and SIGN_B_BIT=0 index constants for sign_mode, shared with the multiplier.
- One natural combinational sub-module, abs_cond_neg. It does conditional two's-complement negation (WIDTH+1 bits) and is used for operand magnitude and result sign fix-up.
- The iteration datapath stays in the top module.

Test Plan:
- Unsigned basic: 100 / 7, mode 00 → quotient 14 (0x000E), remainder 2, div_by_zero=0, done exactly 18 cycles after start.
- Signed basic: 0xFF9C (-100) / 7, mode 11 → quotient 0xFFF2 (-14), remainder 0xFFFE (-2).
- Corner cases, mode 11:
  - 0x8000 / 0xFFFF → quotient 0x8000, remainder 0.
  - 0x8000 / 0x8000 → quotient 1, remainder 0.
  - 0x7FFF / 0x8000 → quotient 0, remainder 0x7FFF.
- Mixed modes:
  - 0xFFF6 / 0x0003, mode 10 → quotient 0xFFFD (-3), remainder 0xFFFF (-1).
  - 0x000A / 0xFFFD, mode 01 → quotient 0xFFFD, remainder 0x0001.
  - 0xFFFF / 0x0002, mode 00 → quotient 0x7FFF, remainder 1.
- Divide by zero: 1234 / 0, mode 00 → quotient 0xFFFF, remainder 1234, div_by_zero=1, done 1 cycle after start. The next normal divide clears div_by_zero.
- Handshake and reset:
  - start pulsed mid-CALC with other operands → the first result is unaffected.
  - rst_n low mid-CALC → all outputs 0 asynchronously, no done pulse.
  - start in the done cycle → accepted.
  - 400 random operations across all four modes checked against a golden model that uses truncation toward zero with WIDTH-bit wrap.

Source files
------------

// File: rtl/arith_pkg.sv
// Definitions shared by the sequential arithmetic units (divider and Booth multiplier).
package arith_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StFixup = 2'd2,
    StDone  = 2'd3
  } arith_state_e;

  // Bit positions within sign_mode: [1] operand A (dividend) signed, [0] operand B signed.
  localparam int unsigned SIGN_A_BIT = 1;
  localparam int unsigned SIGN_B_BIT = 0;

endpackage

// File: rtl/abs_cond_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module abs_cond_neg #(
  parameter int unsigned Width = 17
) (
  input  logic [Width-1:0] value,
  input  logic             negate,
  output logic [Width-1:0] result
);

  assign result = negate ? ((~value) + Width'(1)) : value;

endmodule

// File: rtl/seq_divider_su.sv
// Iterative radix-2 non-restoring divider with per-operand signedness and C-style truncation.
module seq_divider_su
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  arith_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH+1:0] pr_q, pr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   dmag_q, dmag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             div_zero;
  logic             sign_a, sign_b;
  logic [WIDTH:0]   mag_a, mag_b;
  logic [WIDTH+1:0] pr_shift, pr_step, pr_fix;
  logic             q_bit;
  logic [WIDTH:0]   q_fix, r_fix;
  logic             unused_bits;

  // DONE counts as idle for the handshake, so a start in the done cycle is taken.
  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign div_zero = (divisor == '0);

  assign sign_a = sign_mode[SIGN_A_BIT] & dividend[WIDTH-1];
  assign sign_b = sign_mode[SIGN_B_BIT] & divisor[WIDTH-1];

  abs_cond_neg #(.Width(WIDTH + 1)) u_abs_a (
    .value  ({sign_a, dividend}),
    .negate (sign_a),
    .result (mag_a)
  );

  abs_cond_neg #(.Width(WIDTH + 1)) u_abs_b (
    .value  ({sign_b, divisor}),
    .negate (sign_b),
    .result (mag_b)
  );

  // Shift next dividend bit into the partial remainder, then add or subtract by its sign.
  assign pr_shift = {pr_q[WIDTH:0], acc_q[WIDTH-1]};
  assign pr_step  = pr_q[WIDTH+1] ? (pr_shift + {1'b0, dmag_q}) : (pr_shift - {1'b0, dmag_q});
  assign q_bit    = ~pr_step[WIDTH+1];
  assign pr_fix   = pr_q[WIDTH+1] ? (pr_q + {1'b0, dmag_q}) : pr_q;

  abs_cond_neg #(.Width(WIDTH + 1)) u_fix_q (
    .value  ({1'b0, acc_q}),
    .negate (q_neg_q),
    .result (q_fix)
  );

  abs_cond_neg #(.Width(WIDTH + 1)) u_fix_r (
    .value  (pr_fix[WIDTH:0]),
    .negate (r_neg_q),
    .result (r_fix)
  );

  // Magnitudes and the corrected remainder always fit in WIDTH bits.
  assign unused_bits = ^{mag_a[WIDTH], pr_fix[WIDTH+1], q_fix[WIDTH], r_fix[WIDTH]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = div_zero ? StDone : StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StFixup;
        end
      end
      StFixup: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StCalc, StFixup: busy = 1'b1;
      StDone:          done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-state.
  always_comb begin
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    acc_d       = acc_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          dmag_d  = mag_b;
          acc_d   = mag_a[WIDTH-1:0];
          pr_d    = '0;
          cnt_d   = CntW'(WIDTH - 1);
          q_neg_d = sign_a ^ sign_b;
          r_neg_d = sign_a;
          if (div_zero) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      StCalc: begin
        pr_d  = pr_step;
        acc_d = {acc_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - CntW'(1);
      end
      StFixup: begin
        quotient_d  = q_fix[WIDTH-1:0];
        remainder_d = r_fix[WIDTH-1:0];
        dbz_d       = 1'b0;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pr_q        <= '0;
      acc_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      acc_q       <= acc_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_su.sv
// Directed and randomised checks of seq_divider_su at WIDTH=16.
module tb_seq_divider_su;

  localparam int unsigned W = 16;
  localparam int MaxWait = 100;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [1:0]   sign_mode;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  seq_divider_su #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at the next negedge; returns outputs in the done cycle.
  // lat = 1 means done is high in the cycle right after the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                       output int lat);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    sign_mode = m;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  // Truncating division on sign/zero-extended operands, low W bits kept.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] m, output logic [W-1:0] q,
                                output logic [W-1:0] r, output logic z);
    longint sa, sb, sq, sr;
    sa = m[1] ? longint'($signed(a)) : longint'(a);
    sb = m[0] ? longint'($signed(b)) : longint'(b);
    if (sb == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      z  = 1'b0;
    end
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    sign_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs q=%h r=%h done=%b busy=%b dbz=%b, want all 0",
               quotient, remainder, done, busy, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [13] = '{16'd100, 16'hFF9C, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFF6,
                              16'h000A, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0005, 16'hFFFB,
                              16'h0003};
    logic [W-1:0] tb [13] = '{16'd7, 16'h0007, 16'hFFFF, 16'h8000, 16'h8000, 16'h0003,
                              16'hFFFD, 16'h0002, 16'hFFFF, 16'hFFFF, 16'h0009, 16'h0002,
                              16'hFFFF};
    logic [1:0]   tm [13] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00,
                              2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
    logic [W-1:0] eq [13] = '{16'h000E, 16'hFFF2, 16'h8000, 16'h0001, 16'h0000, 16'hFFFD,
                              16'hFFFD, 16'h7FFF, 16'h0001, 16'h0001, 16'h0000, 16'hFFFE,
                              16'h0000};
    logic [W-1:0] er [13] = '{16'h0002, 16'hFFFE, 16'h0000, 16'h0000, 16'h7FFF, 16'hFFFF,
                              16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0005, 16'hFFFF,
                              16'h0003};
    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    for (int i = 0; i < 13; i++) begin
      do_op(ta[i], tb[i], tm[i], q, r, z, lat);
      n_vec++;
      if (lat !== 18) begin
        n_err++;
        $display("FAIL dir%0d_latency got %0d cycles, want 18", i, lat);
      end
      n_vec++;
      if (q !== eq[i]) begin
        n_err++;
        $display("FAIL dir%0d_quotient %h/%h m%b got %h, want %h", i, ta[i], tb[i], tm[i], q,
                 eq[i]);
      end
      n_vec++;
      if (r !== er[i]) begin
        n_err++;
        $display("FAIL dir%0d_remainder %h/%h m%b got %h, want %h", i, ta[i], tb[i], tm[i], r,
                 er[i]);
      end
      n_vec++;
      if (z !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_dbz got %b, want 0", i, z);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    do_op(16'd1234, 16'd0, 2'b00, q, r, z, lat);
    n_vec++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL dbz_latency got %0d cycles, want 1", lat);
    end
    n_vec++;
    if ({q, r, z} !== {16'hFFFF, 16'd1234, 1'b1}) begin
      n_err++;
      $display("FAIL dbz_results q=%h r=%h dbz=%b, want ffff 04d2 1", q, r, z);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({quotient, remainder, div_by_zero, done} !== {16'hFFFF, 16'd1234, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL dbz_hold q=%h r=%h dbz=%b done=%b, want ffff 04d2 1 0", quotient,
               remainder, div_by_zero, done);
    end
    do_op(16'd100, 16'd7, 2'b00, q, r, z, lat);
    n_vec++;
    if ({q, r, z} !== {16'h000E, 16'h0002, 1'b0}) begin
      n_err++;
      $display("FAIL dbz_clear q=%h r=%h dbz=%b, want 000e 0002 0", q, r, z);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(posedge clk);
    @(negedge clk);
    dividend  = 16'd100;
    divisor   = 16'd7;
    sign_mode = 2'b00;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_mid_calc got %b, want 1", busy);
    end
    dividend  = 16'hFFFF;
    divisor   = 16'h0003;
    sign_mode = 2'b11;
    start     = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat !== 18) begin
      n_err++;
      $display("FAIL ignore_latency got %0d cycles, want 18", lat);
    end
    n_vec++;
    if ({quotient, remainder} !== {16'h000E, 16'h0002}) begin
      n_err++;
      $display("FAIL ignore_results q=%h r=%h, want 000e 0002", quotient, remainder);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL ignore_no_second_op busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    do_op(16'h0064, 16'h000A, 2'b00, q, r, z, lat);
    // Issued immediately, so the second start is presented in the done cycle.
    do_op(16'hFF9C, 16'h0007, 2'b11, q, r, z, lat);
    n_vec++;
    if (lat !== 18) begin
      n_err++;
      $display("FAIL b2b_latency got %0d cycles, want 18", lat);
    end
    n_vec++;
    if ({q, r, z} !== {16'hFFF2, 16'hFFFE, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_results q=%h r=%h dbz=%b, want fff2 fffe 0", q, r, z);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    logic         saw_done;
    do_op(16'd100, 16'd7, 2'b00, q, r, z, lat);
    @(negedge clk);
    dividend  = 16'hFFFF;
    divisor   = 16'h0003;
    sign_mode = 2'b00;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL async_reset q=%h r=%h done=%b busy=%b dbz=%b, want all 0", quotient,
               remainder, done, busy, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done got activity=%b, want 0", saw_done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er;
    logic [1:0]   m;
    logic         z, ez;
    int           lat;
    for (int i = 0; i < 400; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 7) == 0) b = W'($urandom_range(1, 3));
      m = 2'(i % 4);
      model(a, b, m, eq, er, ez);
      do_op(a, b, m, q, r, z, lat);
      n_vec++;
      if ({q, r, z} !== {eq, er, ez}) begin
        n_err++;
        $display("FAIL rand%0d %h/%h m%b got q=%h r=%h z=%b, want q=%h r=%h z=%b", i, a, b,
                 m, q, r, z, eq, er, ez);
      end
      n_vec++;
      if (lat !== (ez ? 1 : 18)) begin
        n_err++;
        $display("FAIL rand%0d_latency got %0d, want %0d", i, lat, ez ? 1 : 18);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
